// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: state, opcode/funct, ALU and mux-select codes plus decode helpers for the multicycle controller
package mc_ctrl_fsm_pkg;
  typedef enum logic [2:0] {S_IF0 = 3'd0, S_IF1, S_ID, S_EX, S_MEM, S_WB} state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_XOR = 3'd4, ALU_NOR = 3'd5, ALU_SLT = 3'd6;
  localparam logic [1:0] PC_INC = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2;
  localparam logic       SRC_A_PC = 1'b0, SRC_A_RS = 1'b1;
  localparam logic [1:0] SRC_B_RT = 2'd0, SRC_B_4 = 2'd1, SRC_B_SEXT = 2'd2, SRC_B_ZEXT = 2'd3;
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    return f == F_SUB ? ALU_SUB : f == F_AND ? ALU_AND : f == F_OR ? ALU_OR :
           f == F_XOR ? ALU_XOR : f == F_NOR ? ALU_NOR : f == F_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] f);
    return op == OP_RTYPE ? f inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT} :
           op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
  endfunction
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller<->datapath bundle; master=controller (in: run/op/funct/zf, out: enables/selects/status), slave=datapath
interface mc_ctrl_fsm_if;
  import mc_ctrl_fsm_pkg::*;
  logic       run;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zf;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       mem_write;
  logic       illegal;
  logic       instr_done;
  logic [2:0] state_o;
  modport master (
    input  run, op, funct, zf,
    output ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, mem_write, illegal, instr_done, state_o
  );
  modport slave (
    output run, op, funct, zf,
    input  ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
           mem_to_reg, mem_write, illegal, instr_done, state_o
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// mc_alu_dec: combinational ALU function select from (state, op, funct); ADD outside S_EX
module mc_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);
  always_comb begin
    alu_op = state != S_EX ? ALU_ADD :
             op == OP_RTYPE ? funct_alu(funct) :
             op == OP_SLTI ? ALU_SLT :
             op == OP_ANDI ? ALU_AND :
             op == OP_ORI ? ALU_OR :
             op == OP_XORI ? ALU_XOR :
             (op == OP_BEQ || op == OP_BNE) ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle IF/ID/EX/MEM/WB sequencer; ports clk, rst (sync, active-high), bus (mc_ctrl_fsm_if.master)
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input logic clk,
  input logic rst,
  mc_ctrl_fsm_if.master bus
);
  localparam logic [1:0] LAST = 2'(ROM_LAT - 1);
  state_t     state;
  logic [1:0] cnt;
  logic [2:0] alu_op;
  logic r_type, imm_s, imm_z, br, jmp, lw, sw, legal, ex;
  always_comb begin
    r_type = bus.op == OP_RTYPE;
    imm_s  = bus.op inside {OP_ADDI, OP_SLTI, OP_LW, OP_SW};
    imm_z  = bus.op inside {OP_ANDI, OP_ORI, OP_XORI};
    br     = bus.op == OP_BEQ || bus.op == OP_BNE;
    jmp    = bus.op == OP_J;
    lw     = bus.op == OP_LW;
    sw     = bus.op == OP_SW;
    legal  = op_legal(bus.op, bus.funct);
    ex     = state == S_EX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IF0: begin
          if (!bus.run) cnt <= '0;
          else if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_IF1;
          end else cnt <= cnt + 2'd1;
        end
        S_IF1:   state <= S_ID;
        S_ID:    state <= legal ? S_EX : S_IF0;
        S_EX:    state <= (lw || sw) ? S_MEM : (br || jmp) ? S_IF0 : S_WB;
        S_MEM:   state <= lw ? S_WB : S_IF0;
        default: state <= S_IF0;
      endcase
    end
  end
  mc_alu_dec u_alu_dec (.state(state), .op(bus.op), .funct(bus.funct), .alu_op(alu_op));
  // Write enables and pulses are masked by rst so a reset landing mid-instruction never commits anything.
  always_comb begin
    bus.ir_write   = !rst && state == S_IF1;
    bus.pc_write   = !rst && (state == S_IF1 ||
                     (ex && (jmp || (bus.op == OP_BEQ && bus.zf) || (bus.op == OP_BNE && !bus.zf))));
    bus.pc_src     = ex && br ? PC_BR : ex && jmp ? PC_JMP : PC_INC;
    bus.alu_src_a  = ex && !jmp ? SRC_A_RS : SRC_A_PC;
    bus.alu_src_b  = !ex ? SRC_B_RT : imm_s ? SRC_B_SEXT : imm_z ? SRC_B_ZEXT : SRC_B_RT;
    bus.alu_op     = alu_op;
    bus.reg_write  = !rst && state == S_WB;
    bus.reg_dst    = state == S_WB && r_type;
    bus.mem_to_reg = state == S_WB && lw;
    bus.mem_write  = !rst && state == S_MEM && sw;
    bus.illegal    = !rst && state == S_ID && !legal;
    bus.instr_done = !rst && ((ex && (br || jmp)) || (state == S_MEM && sw) || state == S_WB);
    bus.state_o    = state;
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed-vector self-checking bench for mc_ctrl_fsm at ROM_LAT=1 and ROM_LAT=3
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mc_ctrl_fsm_if b1();
  mc_ctrl_fsm_if b3();
  assign b3.run   = b1.run;
  assign b3.op    = b1.op;
  assign b3.funct = b1.funct;
  assign b3.zf    = b1.zf;
  mc_ctrl_fsm #(.ROM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mc_ctrl_fsm #(.ROM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  int n_tests = 0;
  int n_fail = 0;
  int lat, rw_cyc, rw_n, mw_cyc, mw_n, ill_cyc, done_n;
  logic rdst, m2r, pcw_ex, srca_ex, post_done;
  logic [1:0] pcsrc_ex, srcb_ex;
  logic [2:0] aluop_ex, post_state;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic exec(input logic [5:0] o, input logic [5:0] f, input logic z);
    b1.op = o;
    b1.funct = f;
    b1.zf = z;
    b1.run = 1'b1;
    lat = 0; rw_cyc = 0; rw_n = 0; mw_cyc = 0; mw_n = 0; ill_cyc = 0; done_n = 0;
    rdst = 0; m2r = 0; pcw_ex = 0; srca_ex = 0; pcsrc_ex = 0; srcb_ex = 0; aluop_ex = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      #1;
      if (b1.reg_write) begin
        rw_n++;
        if (rw_cyc == 0) begin
          rw_cyc = k;
          rdst = b1.reg_dst;
          m2r = b1.mem_to_reg;
        end
      end
      if (b1.mem_write) begin
        mw_n++;
        if (mw_cyc == 0) mw_cyc = k;
      end
      if (b1.state_o == 3'd3) begin
        pcw_ex = b1.pc_write;
        pcsrc_ex = b1.pc_src;
        srca_ex = b1.alu_src_a;
        srcb_ex = b1.alu_src_b;
        aluop_ex = b1.alu_op;
      end
      if (b1.illegal) ill_cyc = k;
      if (b1.instr_done) done_n++;
      if (b1.instr_done || b1.illegal) lat = k;
      step;
    end
    #1;
    post_state = b1.state_o;
    post_done = b1.instr_done;
  endtask
  initial begin
    int ir1, ir3, d1, d3, viol;
    b1.run = 1'b1; b1.op = 6'h00; b1.funct = 6'h20; b1.zf = 1'b0;
    rst = 1'b1;
    step; step; #1;
    check("rst_state", b1.state_o, 3'd0);
    check("rst_en", {b1.ir_write, b1.pc_write, b1.reg_write, b1.mem_write}, 4'b0000);
    check("rst_sel", {b1.pc_src, b1.alu_src_a, b1.alu_src_b}, 5'd0);
    check("rst_state_l3", b3.state_o, 3'd0);
    rst = 1'b0;
    ir1 = 0; ir3 = 0; d1 = 0; d3 = 0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (b1.ir_write && ir1 == 0) ir1 = k;
      if (b3.ir_write && ir3 == 0) ir3 = k;
      if (b1.instr_done && d1 == 0) d1 = k;
      if (b3.instr_done && d3 == 0) d3 = k;
      step;
    end
    check("ir_cycle_l1", ir1, 2);
    check("ir_cycle_l3", ir3, 4);
    check("add_done_l1", d1, 5);
    check("add_done_l3", d3, 7);
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    exec(OP_RTYPE, F_ADD, 1'b0);
    check("add_lat", lat, 5);
    check("add_rw_cyc", rw_cyc, 5);
    check("add_rdst", rdst, 1);
    check("add_rw_n", rw_n, 1);
    check("add_done_n", done_n, 1);
    check("add_post_done", post_done, 0);
    check("add_post_state", post_state, 3'd0);
    check("add_ex_sel", {srca_ex, srcb_ex, aluop_ex}, {1'b1, 2'd0, 3'd0});
    exec(OP_RTYPE, F_SUB, 1'b0);
    check("sub_aluop", aluop_ex, 3'd1);
    check("sub_lat", lat, 5);
    exec(OP_RTYPE, F_SLT, 1'b0);
    check("slt_aluop", aluop_ex, 3'd6);
    exec(OP_RTYPE, F_NOR, 1'b0);
    check("nor_aluop", aluop_ex, 3'd5);
    exec(OP_ADDI, 6'h15, 1'b0);
    check("addi_ex", {srca_ex, srcb_ex, aluop_ex}, {1'b1, 2'd2, 3'd0});
    check("addi_rdst", rdst, 0);
    check("addi_lat", lat, 5);
    exec(OP_SLTI, 6'h00, 1'b0);
    check("slti_ex", {srcb_ex, aluop_ex}, {2'd2, 3'd6});
    exec(OP_ORI, 6'h00, 1'b0);
    check("ori_ex", {srcb_ex, aluop_ex}, {2'd3, 3'd3});
    exec(OP_LW, 6'h00, 1'b0);
    check("lw_lat", lat, 6);
    check("lw_rw_cyc", rw_cyc, 6);
    check("lw_m2r", m2r, 1);
    check("lw_rdst", rdst, 0);
    check("lw_mw_n", mw_n, 0);
    check("lw_ex", {srca_ex, srcb_ex, aluop_ex}, {1'b1, 2'd2, 3'd0});
    exec(OP_SW, 6'h00, 1'b0);
    check("sw_lat", lat, 5);
    check("sw_mw_cyc", mw_cyc, 5);
    check("sw_mw_n", mw_n, 1);
    check("sw_rw_n", rw_n, 0);
    exec(OP_BEQ, 6'h00, 1'b1);
    check("beq_t_pc", {pcw_ex, pcsrc_ex}, {1'b1, 2'd1});
    check("beq_t_aluop", aluop_ex, 3'd1);
    check("beq_lat", lat, 4);
    exec(OP_BEQ, 6'h00, 1'b0);
    check("beq_nt_pcw", pcw_ex, 0);
    check("beq_nt_lat", lat, 4);
    exec(OP_BNE, 6'h00, 1'b0);
    check("bne_t_pc", {pcw_ex, pcsrc_ex}, {1'b1, 2'd1});
    exec(OP_BNE, 6'h00, 1'b1);
    check("bne_nt_pcw", pcw_ex, 0);
    exec(OP_J, 6'h00, 1'b0);
    check("j_pc", {pcw_ex, pcsrc_ex}, {1'b1, 2'd2});
    check("j_lat", lat, 4);
    check("j_rw_n", rw_n, 0);
    exec(6'h3F, 6'h00, 1'b0);
    check("ill_op_cyc", ill_cyc, 3);
    check("ill_op_writes", rw_n + mw_n, 0);
    check("ill_op_done_n", done_n, 0);
    check("ill_op_post", post_state, 3'd0);
    exec(OP_RTYPE, 6'h08, 1'b0);
    check("ill_funct_cyc", ill_cyc, 3);
    check("ill_funct_writes", rw_n + mw_n, 0);
    b1.op = OP_LW; b1.funct = 6'h00; b1.zf = 1'b0; b1.run = 1'b1;
    step; step; step; #1;
    check("lw_rst_in_ex", b1.state_o, 3'd3);
    rst = 1'b1;
    step; #1;
    check("lw_rst_state", b1.state_o, 3'd0);
    check("lw_rst_writes", {b1.reg_write, b1.mem_write, b1.pc_write, b1.ir_write}, 4'b0000);
    rst = 1'b0;
    b1.run = 1'b0;
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      step; #1;
      if (b1.state_o != 3'd0 || b1.reg_write || b1.mem_write || b1.ir_write || b1.instr_done) viol++;
    end
    check("hold_run0", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
